// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin arbiter sharing one FIFO write port between NUM_REQ producers
// A one-entry output stage decouples the grant from the FIFO write, so req_i never reaches fifo_write_o combinationally.
module fifo_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ-1:0][31:0]     req_data_i,
  output logic [NUM_REQ-1:0]           ack_o,
  input  logic                         fifo_full_i,
  output logic                         fifo_write_o,
  output logic [31:0]                  fifo_write_data_o,
  output logic [ID_W-1:0]              fifo_write_id_o,
  output logic                         stage_valid_o
);

  generate
    if (NUM_REQ < 2) begin : g_param_check
      $error("fifo_write_arbiter: NUM_REQ must be at least 2");
    end
  endgenerate

  logic            stage_valid_q, stage_valid_d;
  logic [31:0]     stage_data_q, stage_data_d;
  logic [ID_W-1:0] stage_id_q, stage_id_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;

  logic            accept;
  logic            grant_found;
  logic            grant_valid;
  logic [ID_W-1:0] grant_idx;
  int              rank;
  int              best_rank;

  assign fifo_write_o      = stage_valid_q & ~fifo_full_i & ~reset_i;
  assign fifo_write_data_o = stage_data_q;
  assign fifo_write_id_o   = stage_id_q;
  assign stage_valid_o     = stage_valid_q;

  assign accept      = ~stage_valid_q | fifo_write_o;
  assign grant_valid = accept & ~reset_i & grant_found;

  // Rank 0 is the requester just after last_grant; lowest ranked active requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    rank        = 0;
    best_rank   = NUM_REQ;
    for (int p = 0; p < NUM_REQ; p++) begin
      rank = (p + NUM_REQ - 1 - int'(last_grant_q)) % NUM_REQ;
      if (req_i[p] && (rank < best_rank)) begin
        best_rank   = rank;
        grant_idx   = ID_W'(p);
        grant_found = 1'b1;
      end
    end
  end

  always_comb begin
    ack_o = '0;
    for (int p = 0; p < NUM_REQ; p++) begin
      ack_o[p] = grant_valid && (grant_idx == ID_W'(p));
    end
  end

  // A grant refills the stage even while the old word drains this cycle.
  always_comb begin
    stage_valid_d = stage_valid_q;
    stage_data_d  = stage_data_q;
    stage_id_d    = stage_id_q;
    last_grant_d  = last_grant_q;
    if (grant_valid) begin
      stage_valid_d = 1'b1;
      stage_data_d  = req_data_i[grant_idx];
      stage_id_d    = grant_idx;
      last_grant_d  = grant_idx;
    end else if (fifo_write_o) begin
      stage_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      stage_id_q    <= '0;
      last_grant_q  <= ID_W'(NUM_REQ - 1);
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_data_q  <= stage_data_d;
      stage_id_q    <= stage_id_d;
      last_grant_q  <= last_grant_d;
    end
  end

  a_ack_onehot : assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(ack_o));
  a_no_write_when_full : assert property (@(posedge clk_i) !(fifo_write_o && fifo_full_i));

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - scoreboard bench for fifo_write_arbiter with directed and random phases
module tb_fifo_write_arbiter;
  localparam int N        = 4;
  localparam int FIFO_CAP = 6;

  logic                 clk;
  logic                 reset;
  logic [N-1:0]         req;
  logic [N-1:0][31:0]   data;
  logic [N-1:0]         ack_o;
  logic                 full;
  logic                 fifo_write_o;
  logic [31:0]          fifo_write_data_o;
  logic [1:0]           fifo_write_id_o;
  logic                 stage_valid_o;

  fifo_write_arbiter #(.NUM_REQ(N)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .req_i            (req),
    .req_data_i       (data),
    .ack_o            (ack_o),
    .fifo_full_i      (full),
    .fifo_write_o     (fifo_write_o),
    .fifo_write_data_o(fifo_write_data_o),
    .fifo_write_id_o  (fifo_write_id_o),
    .stage_valid_o    (stage_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] d;
  } ent_t;

  ent_t         exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  bit           checking = 0;
  bit           m_sv     = 0;
  int           m_last   = N - 1;
  logic [N-1:0] obs_ack  = '0;
  int           ack_count = 0;
  bit           use_fifo = 0;
  bit           rd_req   = 0;
  int           fcount   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: stage is one slot; winner is the first requester after the previous winner, modulo N.
  always @(negedge clk) begin : model
    int           win;
    bit           ew;
    bit           acc;
    logic [N-1:0] eack;
    obs_ack = ack_o;
    if (checking) begin
      ew   = m_sv && !full && !reset;
      acc  = !m_sv || ew;
      win  = -1;
      if (acc && !reset) begin
        for (int k = 1; k <= N; k++) begin
          if (win < 0 && req[(m_last + k) % N]) win = (m_last + k) % N;
        end
      end
      eack = '0;
      if (win >= 0) eack[win] = 1'b1;
      chk("ack", ack_o, eack);
      chk("fifo_write", fifo_write_o, ew);
      chk("stage_valid", stage_valid_o, m_sv);
      if (ack_o != '0) ack_count++;
      if (reset) begin
        m_sv   = 0;
        m_last = N - 1;
        exp_q.delete();
      end else if (win >= 0) begin
        exp_q.push_back('{id: win, d: data[win]});
        m_last = win;
        m_sv   = 1;
      end else if (ew) begin
        m_sv = 0;
      end
      if (use_fifo) begin
        if (fifo_write_o === 1'b1) fcount++;
        if (rd_req && fcount > 0) fcount--;
      end
    end
  end

  always @(negedge clk) begin : monitor
    ent_t e;
    if (checking && fifo_write_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("write_unexpected", 64'(fifo_write_data_o), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("write_data", fifo_write_data_o, e.d);
        chk("write_id", fifo_write_id_o, e.id);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    int a0;
    reset = 1'b1;
    req   = '1;
    full  = 1'b0;
    for (int p = 0; p < N; p++) data[p] = 32'h1000 + p;
    tick();
    checking = 1;

    // reset with all requesting, then rotation
    smp();
    chk("rst_ack", ack_o, 0);
    chk("rst_write", fifo_write_o, 0);
    tick();
    reset = 1'b0;
    smp();
    chk("first_ack", ack_o, 4'b0001);
    for (int i = 1; i <= 4; i++) begin
      tick();
      smp();
      chk("rr_ack", ack_o, 4'b0001 << (i % 4));
      chk("rr_write", fifo_write_o, 1);
      chk("rr_id", fifo_write_id_o, i - 1);
      chk("rr_data", fifo_write_data_o, 32'h1000 + i - 1);
    end

    // single requester 2 with last_grant 3
    tick();
    reset = 1'b1;
    req   = '0;
    tick();
    reset = 1'b0;
    smp();
    tick();
    req     = 4'b0100;
    data[2] = 32'hDEAD_BEEF;
    smp();
    chk("single_ack", ack_o, 4'b0100);
    tick();
    req = '0;
    smp();
    chk("single_write", fifo_write_o, 1);
    chk("single_data", fifo_write_data_o, 32'hDEAD_BEEF);
    chk("single_id", fifo_write_id_o, 2);
    tick();
    req = '1;
    smp();
    chk("lg_after_2", ack_o, 4'b1000);
    tick();
    req = '0;
    tick();

    // backpressure for 3 cycles
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req   = 4'b1000;
    smp();
    chk("bp_prime_ack", ack_o, 4'b1000);
    tick();
    req  = 4'b0011;
    full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("bp_ack", ack_o, 0);
      chk("bp_write", fifo_write_o, 0);
      tick();
    end
    full = 1'b0;
    smp();
    chk("bp_release_write", fifo_write_o, 1);
    chk("bp_release_id", fifo_write_id_o, 3);
    chk("bp_release_ack", ack_o, 4'b0001);

    // reset while staged word is blocked
    tick();
    req   = 4'b0010;
    full  = 1'b1;
    reset = 1'b1;
    smp();
    chk("rst_full_write", fifo_write_o, 0);
    chk("rst_full_ack", ack_o, 0);
    tick();
    reset = 1'b0;
    req   = 4'b0011;
    smp();
    chk("post_rst_stage", stage_valid_o, 0);
    chk("post_rst_ack", ack_o, 4'b0001);
    tick();
    req  = 4'b0010;
    full = 1'b0;
    tick();
    req = '0;
    tick();
    tick();

    // backpressure from a bounded FIFO with no reads, then 3 reads
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    fcount   = 0;
    use_fifo = 1;
    ack_count = 0;
    req = '1;
    for (int p = 0; p < N; p++) data[p] = $urandom;
    for (int c = 0; c < 25; c++) begin
      smp();
      tick();
      for (int p = 0; p < N; p++) if (obs_ack[p]) data[p] = $urandom;
      full = (fcount >= FIFO_CAP);
    end
    chk("fifo_fill_acks", ack_count, FIFO_CAP + 1);
    a0 = ack_count;
    for (int c = 0; c < 23; c++) begin
      rd_req = (c < 3);
      smp();
      tick();
      for (int p = 0; p < N; p++) if (obs_ack[p]) data[p] = $urandom;
      full = (fcount >= FIFO_CAP);
    end
    rd_req = 0;
    chk("fifo_read_acks", ack_count - a0, 3);
    use_fifo = 0;
    req   = '0;
    full  = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // random traffic
    for (int c = 0; c < 600; c++) begin
      smp();
      tick();
      reset = ($urandom_range(0, 63) == 0);
      full  = ($urandom_range(0, 2) == 0);
      for (int p = 0; p < N; p++) begin
        if (obs_ack[p]) begin
          req[p]  = 1'($urandom_range(0, 1));
          data[p] = $urandom;
        end else if (!req[p] && $urandom_range(0, 2) == 0) begin
          req[p]  = 1'b1;
          data[p] = $urandom;
        end
      end
    end
    req   = '0;
    full  = 1'b0;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      smp();
      tick();
    end
    chk("drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
